// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction encodings and sizing helper for the up/down counter
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Ceiling log2 for n >= 1; returns 0 for n == 1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_en_prescaler.sv
// rtl/clk_en_prescaler.sv - divides the count enable by DIV and emits a one-cycle step
module clk_en_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int PW = (DIV > 1) ? clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_cnt;

    if (DIV < 1) begin : g_bad_div
        $error("clk_en_prescaler: DIV must be >= 1");
    end

    // With DIV == 1 LAST is zero, so pre_cnt never leaves 0 and step follows en.
    assign step = en && (pre_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            if (pre_cnt == LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo-MOD up/down counter with prescaler, load, tc and wrap
// Optional COUNTER_SATURATE_EN: hold at the limit instead of wrapping.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 2 ** WIDTH,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             step,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH:0]   MAX_W = MOD_W - (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] MAX   = MAX_W[WIDTH-1:0];

    if (WIDTH < 1) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be >= 1");
    end
    if (MOD < 2 || MOD > 2 ** WIDTH) begin : g_bad_mod
        $error("mod_updown_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end
    if (DIV < 1) begin : g_bad_div
        $error("mod_updown_counter: DIV must be >= 1");
    end

    logic [WIDTH-1:0] load_clamped;

    clk_en_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .step  (step)
    );

    assign load_clamped = (load_val > MAX) ? MAX : load_val;
    assign tc = (up_dn == DIR_UP) ? (q == MAX) : (q == '0);

    always_ff @(posedge clk) begin
        wrap <= 1'b0;
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_clamped;
        end else if (step) begin
            if (up_dn == DIR_DOWN) begin
                if (q == '0) begin
`ifdef COUNTER_SATURATE_EN
                    q <= q;
`else
                    q    <= MAX;
                    wrap <= 1'b1;
`endif
                end else begin
                    q <= q - WIDTH'(1);
                end
            end else begin
                if (q == MAX) begin
`ifdef COUNTER_SATURATE_EN
                    q <= q;
`else
                    q    <= '0;
                    wrap <= 1'b1;
`endif
                end else begin
                    q <= q + WIDTH'(1);
                end
            end
        end
    end

endmodule
